// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock datapath and its time-set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } set_state_t;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MINS_PER_HOUR = 60;
  localparam int unsigned FIELD_W       = 6;

  // Increment with wrap to zero after the last legal value.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                  input logic [FIELD_W-1:0] last);
    return (value == last) ? '0 : value + FIELD_W'(1);
  endfunction

  // Out-of-range counter values are treated as zero when captured for editing.
  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] value,
                                                     input int unsigned modulus);
    return (32'(value) >= modulus) ? '0 : value;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, press pulse
// on the debounced high-to-low transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Level follows the synchronized key only after a full run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: freezes the clock, edits hours then minutes, commits with a load pulse.
// Optional key auto-repeat while editing: define CLOCK_SET_AUTOREPEAT_EN.
import clock_pkg::*;

module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 12_500_000,
  parameter int unsigned HOUR_MAX        = HOURS_PER_DAY,
  parameter int unsigned MIN_MAX         = MINS_PER_HOUR,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iKeyMode,
  input  logic               iKeyInc,
  input  logic [FIELD_W-1:0] iHour,
  input  logic [FIELD_W-1:0] iMinute,
  output logic               oCountEn,
  output logic               oLoad,
  output logic               oClearSec,
  output logic [FIELD_W-1:0] oLoadHour,
  output logic [FIELD_W-1:0] oLoadMin,
  output logic [5:0]         oBlank,
  output logic [1:0]         oMode
);

  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [FIELD_W-1:0] HOUR_LAST  = FIELD_W'(HOUR_MAX - 1);
  localparam logic [FIELD_W-1:0] MIN_LAST   = FIELD_W'(MIN_MAX - 1);

  logic               mode_level;
  logic               mode_press;
  logic               inc_level;
  logic               inc_press;
  logic               inc_evt;
  logic               blink_wrap;
  set_state_t         state;
  logic [FIELD_W-1:0] edit_hour;
  logic [FIELD_W-1:0] edit_min;
  logic [BLINK_W-1:0] blink_cnt;
  logic               unused_sink;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (iClk),
    .rst_n (iRst),
    .key   (iKeyMode),
    .level (mode_level),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk   (iClk),
    .rst_n (iRst),
    .key   (iKeyInc),
    .level (inc_level),
    .press (inc_press)
  );

  assign unused_sink = ^{mode_level, inc_level, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             in_edit;
  logic             rep_active;
  logic             rep_first;
  logic             rep_fire;
  logic [REP_W-1:0] rep_cnt;

  assign in_edit = (state == ST_SET_HOUR) || (state == ST_SET_MIN);

  // Synthetic inc presses while the key stays held; cancelled by release or a mode press.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      rep_active <= 1'b0;
      rep_first  <= 1'b0;
      rep_fire   <= 1'b0;
      rep_cnt    <= '0;
    end else begin
      rep_fire <= 1'b0;
      if (!in_edit || mode_press || inc_level) begin
        rep_active <= 1'b0;
        rep_cnt    <= '0;
      end else if (inc_press) begin
        rep_active <= 1'b1;
        rep_first  <= 1'b1;
        rep_cnt    <= '0;
      end else if (rep_active) begin
        if (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_RATE_LAST)) begin
          rep_fire  <= 1'b1;
          rep_first <= 1'b0;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
    end
  end

  assign inc_evt = inc_press | rep_fire;
`else
  assign inc_evt = inc_press;
`endif

  assign blink_wrap = (blink_cnt == BLINK_LAST);

  // Edit FSM; the blink phase lives directly in the oBlank field bits.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state     <= ST_RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      blink_cnt <= '0;
      oCountEn  <= 1'b1;
      oLoad     <= 1'b0;
      oBlank    <= '0;
    end else begin
      oLoad <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (mode_press) begin
            state     <= ST_SET_HOUR;
            oCountEn  <= 1'b0;
            edit_hour <= clamp_field(iHour, HOUR_MAX);
            edit_min  <= clamp_field(iMinute, MIN_MAX);
            oBlank    <= '0;
            blink_cnt <= '0;
          end
        end
        ST_SET_HOUR: begin
          if (mode_press) begin
            state     <= ST_SET_MIN;
            oBlank    <= '0;
            blink_cnt <= '0;
          end else if (inc_evt) begin
            edit_hour <= wrap_inc(edit_hour, HOUR_LAST);
            oBlank    <= '0;
            blink_cnt <= '0;
          end else if (blink_wrap) begin
            blink_cnt   <= '0;
            oBlank[5:4] <= ~oBlank[5:4];
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        ST_SET_MIN: begin
          if (mode_press) begin
            state     <= ST_COMMIT;
            oLoad     <= 1'b1;
            oBlank    <= '0;
            blink_cnt <= '0;
          end else if (inc_evt) begin
            edit_min  <= wrap_inc(edit_min, MIN_LAST);
            oBlank    <= '0;
            blink_cnt <= '0;
          end else if (blink_wrap) begin
            blink_cnt   <= '0;
            oBlank[3:2] <= ~oBlank[3:2];
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end
        end
        ST_COMMIT: begin
          state    <= ST_RUN;
          oCountEn <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign oClearSec = oLoad;
  assign oLoadHour = edit_hour;
  assign oLoadMin  = edit_min;
  assign oMode     = 2'(state);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized bench for clock_set_ctrl against an event-level model of the set procedure.
module tb_clock_set_ctrl;

  localparam int D = 4;
  localparam int B = 8;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iKeyMode = 1'b1;
  logic       iKeyInc = 1'b1;
  logic [5:0] iHour = '0;
  logic [5:0] iMinute = '0;
  logic       oCountEn;
  logic       oLoad;
  logic       oClearSec;
  logic [5:0] oLoadHour;
  logic [5:0] oLoadMin;
  logic [5:0] oBlank;
  logic [1:0] oMode;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES   (B),
    .HOUR_MAX       (24),
    .MIN_MAX        (60),
    .REPEAT_DELAY   (40),
    .REPEAT_RATE    (20)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iKeyMode  (iKeyMode),
    .iKeyInc   (iKeyInc),
    .iHour     (iHour),
    .iMinute   (iMinute),
    .oCountEn  (oCountEn),
    .oLoad     (oLoad),
    .oClearSec (oClearSec),
    .oLoadHour (oLoadHour),
    .oLoadMin  (oLoadMin),
    .oBlank    (oBlank),
    .oMode     (oMode)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: state, edited values, edge at which the blink phase last restarted.
  int m_state = 0;
  int m_hour = 0;
  int m_min = 0;
  int m_ref = 0;
  int exp_h_q[$];
  int exp_m_q[$];
  int loads_seen = 0;
  int loads_expected = 0;
  bit mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int target);
    while (cyc < target) @(negedge iClk);
  endtask

  function automatic int exp_blank();
    int ph;
    ph = ((cyc - m_ref) / B) % 2;
    if (m_state == 1) return ph * 48;
    if (m_state == 2) return ph * 12;
    return 0;
  endfunction

  // Applies one accepted press; returns the state visible right after the update edge.
  function automatic int apply(input bit m, input bit i, input int upd);
    case (m_state)
      0: if (m) begin
           m_state = 1;
           m_hour  = (int'(iHour) < 24) ? int'(iHour) : 0;
           m_min   = (int'(iMinute) < 60) ? int'(iMinute) : 0;
           m_ref   = upd;
         end
      1: if (m) begin
           m_state = 2;
           m_ref   = upd;
         end else if (i) begin
           m_hour = (m_hour + 1) % 24;
           m_ref  = upd;
         end
      default: if (m) begin
           exp_h_q.push_back(m_hour);
           exp_m_q.push_back(m_min);
           loads_expected++;
           m_state = 0;
           return 3;
         end else if (i) begin
           m_min = (m_min + 1) % 60;
           m_ref = upd;
         end
    endcase
    return m_state;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_mode"}, oMode, m_state);
    check({tag, "_count_en"}, oCountEn, (m_state == 0));
    check({tag, "_hour"}, oLoadHour, m_hour);
    check({tag, "_min"}, oLoadMin, m_min);
    check({tag, "_blank"}, oBlank, exp_blank());
    check({tag, "_load"}, {oLoad, oClearSec}, 0);
  endtask

  // Hold the selected keys low for len cycles, check the edge timing, then settle and check.
  task automatic do_op(input bit m, input bit i, input int len, input int extra);
    int n;
    int upd;
    int old;
    int imm;
    old = m_state;
    n = cyc + 1;
    iKeyMode = ~m;
    iKeyInc = ~i;
    wait_neg(n + len - 1);
    iKeyMode = 1'b1;
    iKeyInc = 1'b1;
    if (len >= D && (m || i)) begin
      upd = n + D + 3;
      wait_neg(upd - 1);
      check("pre_edge_mode", oMode, old);
      imm = apply(m, i, upd);
      wait_neg(upd);
      check("post_edge_mode", oMode, imm);
      check("post_edge_count_en", oCountEn, (imm == 0));
    end
    wait_neg(cyc + D + 6 + extra);
    check_all("settle");
  endtask

  task automatic do_reset(input int n);
    iRst = 1'b0;
    wait_neg(cyc + n);
    iRst = 1'b1;
    m_state = 0;
    m_hour = 0;
    m_min = 0;
    check_all("reset");
  endtask

  // Every load pulse must match a commit the model predicted, one cycle each.
  always @(negedge iClk) begin : load_mon
    int h;
    int mn;
    if (mon_on && (oLoad || oClearSec)) begin
      if (exp_h_q.size() == 0) begin
        check("unexpected_load", {oLoad, oClearSec}, 0);
      end else begin
        h = exp_h_q.pop_front();
        mn = exp_m_q.pop_front();
        loads_seen++;
        check("load_pulse", {oLoad, oClearSec}, 3);
        check("load_hour", oLoadHour, h);
        check("load_min", oLoadMin, mn);
        check("load_mode", oMode, 3);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int len;
    do_reset(2);
    mon_on = 1'b1;

    // Bounce pattern low 3, high 1, low 3 never reaches the debounce threshold.
    iKeyMode = 1'b0; wait_neg(cyc + 3);
    iKeyMode = 1'b1; wait_neg(cyc + 1);
    iKeyMode = 1'b0; wait_neg(cyc + 3);
    iKeyMode = 1'b1; wait_neg(cyc + D + 6);
    check_all("bounce_pair");

    iHour = 6'd22; iMinute = 6'd5;
    do_op(1'b1, 1'b0, 6, 0);
    do_op(1'b0, 1'b1, D, 3);
    do_op(1'b0, 1'b1, D, 9);
    for (int k = 0; k < 4; k++) begin
      wait_neg(cyc + 5);
      check_all("blink");
    end
    do_op(1'b1, 1'b1, D, 0);
    do_op(1'b1, 1'b0, D, 0);

    iHour = 6'd7; iMinute = 6'd59;
    do_op(1'b1, 1'b0, D, 0);
    do_op(1'b1, 1'b0, D + 1, 0);
    do_op(1'b0, 1'b1, D, 0);
    do_op(1'b1, 1'b0, D, 0);
    do_op(1'b0, 1'b1, D + 2, 0);

    iHour = 6'd40; iMinute = 6'd30;
    do_op(1'b1, 1'b0, D, 0);
    do_op(1'b1, 1'b0, D, 0);
    do_reset(1);

    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        if (m_state == 0) begin
          iHour = 6'($urandom_range(0, 1) ? $urandom_range(18, 25) : $urandom_range(0, 63));
          iMinute = 6'($urandom_range(0, 1) ? $urandom_range(56, 61) : $urandom_range(0, 63));
        end
        kind = $urandom_range(0, 5);
        len = $urandom_range(D, D + 3);
        case (kind)
          0, 1: do_op(1'b1, 1'b0, len, $urandom_range(0, 20));
          2, 3: do_op(1'b0, 1'b1, len, $urandom_range(0, 20));
          4: do_op(1'b1, 1'b1, len, $urandom_range(0, 20));
          default: do_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         $urandom_range(1, D - 1), $urandom_range(0, 20));
        endcase
      end
    end

    wait_neg(cyc + 4);
    check("loads_total", loads_seen, loads_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the hours/minutes/seconds clock datapath. It debounces two push-button inputs and runs a small state machine that freezes the counters, lets the user edit hours and then minutes, and commits the result with a one-cycle load pulse. It sits between the board keys and the three `Counter` instances. It gates their seconds strobe and drives per-digit blanking for the `SEG7_LUT` displays.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles before a key level is accepted (20 ms at 50 MHz).
- `BLINK_CYCLES`, 12_500_000: half-period of the edit-field blink.
- `HOUR_MAX`, 24: hour modulus.
- `MIN_MAX`, 60: minute modulus.
- `REPEAT_DELAY`, 25_000_000: cycles held before the first auto-repeat (used only with the macro).
- `REPEAT_RATE`, 5_000_000: cycles between auto-repeats (used only with the macro).

Ports:
- `iClk` in 1: system clock (MAX10_CLK2_50 domain).
- `iRst` in 1: reset, synchronous, active-low.
- `iKeyMode` in 1: raw mode button, active-low, asynchronous to `iClk`.
- `iKeyInc` in 1: raw increment button, active-low, asynchronous to `iClk`.
- `iHour` in 6: current hour counter value.
- `iMinute` in 6: current minute counter value.
- `oCountEn` out 1: high only in RUN; the top level ANDs it with `sec_strobe`.
- `oLoad` out 1: one-cycle commit pulse that loads the hour and minute counters.
- `oClearSec` out 1: identical to `oLoad`; zeroes the seconds counter.
- `oLoadHour` out 6: edited hour; valid while `oLoad` is high.
- `oLoadMin` out 6: edited minute; valid while `oLoad` is high.
- `oBlank` out 6: per-digit blank mask; bit i blanks HEXi.
- `oMode` out 2: current state encoding.

## Operation
Key conditioning (per key):
- 2-FF synchronizer, then a stability counter.
- The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Press event: a one-cycle pulse on the debounced high-to-low transition. Releases produce no event.

States:
- RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3.

Transitions:
- RUN + mode press -> SET_HOUR. On this transition, capture `iHour` into `edit_hour` and `iMinute` into `edit_min`. Any captured value at or above its modulus is clamped to 0.
- SET_HOUR + mode press -> SET_MIN.
- SET_HOUR + inc press -> `edit_hour` = (`edit_hour` == `HOUR_MAX`-1) ? 0 : `edit_hour`+1.
- SET_MIN + mode press -> COMMIT.
- SET_MIN + inc press -> `edit_min` increments and wraps at `MIN_MAX`-1 the same way.
- COMMIT -> RUN unconditionally after one cycle. `oLoad` and `oClearSec` are 1 during COMMIT.
- Inc press in RUN or COMMIT: ignored.
- Mode and inc press in the same cycle: mode wins; the inc press is discarded.

Blinking:
- The blink phase toggles every `BLINK_CYCLES`.
- The phase resets to visible (0) on entry to SET_HOUR or SET_MIN and on every accepted inc press.
- In SET_HOUR, `oBlank[5:4]` = phase; in SET_MIN, `oBlank[3:2]` = phase. All other bits are 0.

Outputs:
- All outputs are registered.
- `oLoadHour` and `oLoadMin` always reflect `edit_hour` and `edit_min`.

## Timing
- Reset (`iRst`=0 at a rising edge):
  - Next cycle: state RUN, `oCountEn`=1, `oLoad`=0, `oClearSec`=0, `oBlank`=0, `oMode`=0, `oLoadHour`=0, `oLoadMin`=0.
  - Debounced levels are 1 (released) and all counters are 0.
- Reset mid-edit returns to RUN with no `oLoad` pulse; the edit is discarded.
- A raw key held low from sample edge N produces its press pulse at edge N+`DEBOUNCE_CYCLES`+2. Bounces shorter than `DEBOUNCE_CYCLES` produce nothing.
- Press pulse at edge t -> state and edit registers update at edge t+1. Outputs derived from state are valid after edge t+1.
- `oLoad` is high for exactly one cycle per commit.
- `oCountEn` drops in the same cycle the state leaves RUN and rises in the cycle after COMMIT. At most one pending `sec_strobe` is lost per edit; this is accepted.

## Configuration
- Macro: `CLOCK_SET_AUTOREPEAT_EN`.
- Defined: while the debounced inc key stays low in SET_HOUR or SET_MIN, a synthetic inc press fires `REPEAT_DELAY` cycles after the real press, then every `REPEAT_RATE` cycles until release or a state change. Synthetic presses follow the same rules as real ones.
- Undefined: exactly one increment per physical press. The repeat logic is absent; the REPEAT_* parameters are present but unused.

## Structure
- Shared package `clock_pkg`:
  - `typedef enum logic [1:0] set_state_t {ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_COMMIT}`.
  - Default moduli constants `HOURS_PER_DAY`=24 and `MINS_PER_HOUR`=60.
- Sub-module `key_debounce` (synchronizer, stability counter, press-pulse output), instantiated once per key.
- Blink counter, FSM and edit registers live in `clock_set_ctrl`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `BLINK_CYCLES`=8.

1. Reset held low 2 cycles, then released -> `oMode`=0, `oCountEn`=1, `oLoad`=0, `oBlank`=0.
2. `iKeyMode` low 3 cycles, high 1, low 3 -> no state change. Then held low 6 cycles -> press at N+6, `oMode`=1 and `oCountEn`=0 one cycle later.
3. `iHour`=22 captured, then two inc presses -> `oLoadHour` becomes 23, then 0. `oBlank[5:4]` toggles every 8 cycles and restarts at 0 after each press.
4. Full edit with `iHour`=7, `iMinute`=59: mode, mode, one inc, mode -> `oLoad`=1 for exactly one cycle with `oLoadHour`=7, `oLoadMin`=0, `oClearSec`=1. Next cycle `oMode`=0.
5. In SET_HOUR, mode and inc press on the same cycle -> `oMode`=2, `edit_hour` unchanged.
6. In SET_MIN with `edit_min`=30, assert `iRst` for 1 cycle -> `oMode`=0, no `oLoad` pulse, `oCountEn`=1.
